// File: rtl/exu_gpr_arb_if.sv
// exu_gpr_arb_if: requester-side bundle of the GPR port arbiter.
//   req/lock : one bit per channel, driven by the execution units (master)
//   gnt      : registered one-hot-or-zero grant (feeds exu_gpr_rw_mux.chn_sels)
//   busy     : OR of gnt
//   owner    : index of the granted channel, 0 when idle
//   wdt_err  : one-cycle pulse on a forced lock release
interface exu_gpr_arb_if #(
  parameter int CHN_NUM = 2
);
  localparam int OW = $clog2(CHN_NUM);

  logic [CHN_NUM-1:0] req;
  logic [CHN_NUM-1:0] lock;
  logic [CHN_NUM-1:0] gnt;
  logic               busy;
  logic [OW-1:0]      owner;
  logic               wdt_err;

  modport master (output req, lock, input gnt, busy, owner, wdt_err);
  modport slave  (input req, lock, output gnt, busy, owner, wdt_err);
endinterface

// File: rtl/exu_gpr_arb.sv
// exu_gpr_arb: round-robin owner selection for the shared GPR read/write port.
// A granted channel keeps the port while it holds req and lock; otherwise the
// port is handed to the next requester in round-robin order with no bubble.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   arb        : exu_gpr_arb_if.slave (req/lock in; gnt/busy/owner/wdt_err out)
// Parameters: CHN_NUM (2..8), MAX_HOLD (2..255, watchdog only).
// Build option: define EXU_GPR_ARB_WDT_EN to bound lock duration; an expired
// owner is skipped in the following arbitration and wdt_err pulses.
module exu_gpr_arb #(
  parameter int CHN_NUM  = 2,
  parameter int MAX_HOLD = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  exu_gpr_arb_if.slave    arb
);
  localparam int OW = $clog2(CHN_NUM);

  if (CHN_NUM < 2 || CHN_NUM > 8 || MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_param
    $error("exu_gpr_arb: CHN_NUM or MAX_HOLD out of range");
  end

  typedef enum logic {IDLE, GRANT} state_e;

  state_e             state_q, state_d;
  logic [CHN_NUM-1:0] gnt_q, gnt_d;
  logic [OW-1:0]      owner_q, owner_d;
  logic [OW-1:0]      last_q, last_d;
  logic               busy_q;
  logic               wdt_q, wdt_d;
  logic               hold, expire, found;
  logic [OW-1:0]      win;
  logic [CHN_NUM-1:0] excl, elig;

  // owner_q is only meaningful in GRANT, which the state term guards
  assign hold = (state_q == GRANT) && arb.req[owner_q] && arb.lock[owner_q];

`ifdef EXU_GPR_ARB_WDT_EN
  logic [7:0] cnt_q, cnt_d;
  assign expire = hold && (cnt_q == 8'(MAX_HOLD - 1));
`else
  assign expire = 1'b0;
`endif

  // An expired owner sits out exactly one arbitration
  always_comb begin
    excl          = '0;
    excl[owner_q] = expire;
  end
  assign elig = arb.req & ~excl;

  // Search last+1 .. last+CHN_NUM (mod CHN_NUM): previous owner checked last
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int k = 1; k <= CHN_NUM; k++) begin
      if (!found && elig[(int'(last_q) + k) % CHN_NUM]) begin
        found = 1'b1;
        win   = OW'((int'(last_q) + k) % CHN_NUM);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    owner_d = owner_q;
    last_d  = last_q;
    wdt_d   = expire;
`ifdef EXU_GPR_ARB_WDT_EN
    cnt_d   = '0;
`endif
    if (hold && !expire) begin
      state_d = GRANT;
`ifdef EXU_GPR_ARB_WDT_EN
      cnt_d   = cnt_q + 8'd1;
`endif
    end else if (found) begin
      state_d    = GRANT;
      gnt_d      = '0;
      gnt_d[win] = 1'b1;
      owner_d    = win;
      last_d     = win;
    end else begin
      state_d = IDLE;
      gnt_d   = '0;
      owner_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      owner_q <= '0;
      last_q  <= OW'(CHN_NUM - 1);
      busy_q  <= 1'b0;
      wdt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      busy_q  <= (state_d == GRANT);
      wdt_q   <= wdt_d;
    end
  end

`ifdef EXU_GPR_ARB_WDT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`endif

  assign arb.gnt     = gnt_q;
  assign arb.busy    = busy_q;
  assign arb.owner   = owner_q;
  assign arb.wdt_err = wdt_q;
endmodule

// File: tb/tb_exu_gpr_arb.sv
module tb_exu_gpr_arb;
  localparam int N  = 2;
  localparam int MH = 4;
`ifdef EXU_GPR_ARB_WDT_EN
  localparam bit WDT = 1'b1;
`else
  localparam bit WDT = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  exu_gpr_arb_if #(.CHN_NUM(N)) bus ();
  exu_gpr_arb #(.CHN_NUM(N), .MAX_HOLD(MH)) dut (.clk(clk), .rst_n(rst_n), .arb(bus));

  int n_chk  = 0;
  int n_pass = 0;
  bit rnd_on = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Reference model: current owner (-1 = nobody), most recent owner, length
  // of the current lock run, and whether the last step was a forced release.
  int m_owner = -1;
  int m_last  = N - 1;
  int m_cnt   = 0;
  bit m_wdt   = 1'b0;
  int waitc [N];
  int wait_bound;

  initial begin
    int pick, c, exp_gnt;
    bit hold, expire;
    wait_bound = WDT ? (N - 1) * MH : 1000000;
    foreach (waitc[i]) waitc[i] = 0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_owner = -1; m_last = N - 1; m_cnt = 0; m_wdt = 1'b0;
        foreach (waitc[i]) waitc[i] = 0;
      end else begin
        hold   = (m_owner >= 0) && bus.req[m_owner] && bus.lock[m_owner];
        expire = WDT && hold && (m_cnt == MH - 1);
        m_wdt  = expire;
        if (hold && !expire) m_cnt++;
        else begin
          pick = -1;
          for (int k = 1; k <= N; k++) begin
            c = (m_last + k) % N;
            if (pick < 0 && bus.req[c] && !(expire && c == m_owner)) pick = c;
          end
          m_owner = pick;
          if (pick >= 0) m_last = pick;
          m_cnt = 0;
        end
      end
      #1;
      exp_gnt = (m_owner < 0) ? 0 : (1 << m_owner);
      chk("gnt",     int'(bus.gnt),     exp_gnt);
      chk("busy",    int'(bus.busy),    int'(m_owner >= 0));
      chk("owner",   int'(bus.owner),   (m_owner < 0) ? 0 : m_owner);
      chk("wdt_err", int'(bus.wdt_err), int'(m_wdt));
      chk("onehot0", int'($onehot0(bus.gnt)), 1);
      chk("busy_or", int'(bus.busy), int'(|bus.gnt));
      if (rnd_on) begin
        for (int i = 0; i < N; i++) begin
          if (bus.req[i] && !bus.gnt[i]) waitc[i]++;
          else waitc[i] = 0;
          chk("starve", int'(waitc[i] <= wait_bound), 1);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, got %0d checks", n_chk);
    $fatal(1, "timeout");
  end

  initial begin
    bus.req  = '0;
    bus.lock = '0;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_gnt",   int'(bus.gnt), 0);
    chk("rst_busy",  int'(bus.busy), 0);
    chk("rst_owner", int'(bus.owner), 0);
    chk("rst_wdt",   int'(bus.wdt_err), 0);

    // both requesting, no lock: strict alternation starting at ch0
    bus.req = 2'b11; rst_n = 1'b1;
    @(negedge clk); chk("rr_c1", int'(bus.gnt), 1);
    @(negedge clk); chk("rr_c2", int'(bus.gnt), 2);
    @(negedge clk); chk("rr_c3", int'(bus.gnt), 1);
    @(negedge clk); chk("rr_c4", int'(bus.gnt), 2);
    bus.req = 2'b00;
    @(negedge clk); chk("rr_idle", int'(bus.gnt), 0);

    // lone ch1 re-granted every cycle
    bus.req = 2'b10;
    @(negedge clk); chk("single_c1", int'(bus.gnt), 2); chk("single_owner", int'(bus.owner), 1);
    @(negedge clk); chk("single_c2", int'(bus.gnt), 2);
    @(negedge clk); chk("single_c3", int'(bus.gnt), 2);
    bus.req = 2'b00;
    @(negedge clk); chk("single_idle", int'(bus.busy), 0);

    // ch0 locks for 4 granted cycles, ch1 takes over with no gap
    bus.req = 2'b11; bus.lock = 2'b01;
    repeat (3) begin @(negedge clk); chk("lock_hold", int'(bus.gnt), 1); end
    @(negedge clk); chk("lock_hold4", int'(bus.gnt), 1);
    bus.lock = 2'b00;
    @(negedge clk); chk("lock_handoff", int'(bus.gnt), 2); chk("lock_no_wdt", int'(bus.wdt_err), 0);
    bus.req = 2'b00;
    @(negedge clk); chk("post_lock_idle", int'(bus.gnt), 0);

    // ch0 locked forever: watchdog forces a release after MAX_HOLD cycles
    bus.req = 2'b01; bus.lock = 2'b01;
    repeat (4) begin @(negedge clk); chk("wdt_hold", int'(bus.gnt), 1); end
    @(negedge clk);
    chk("wdt_gnt",   int'(bus.gnt),     WDT ? 0 : 1);
    chk("wdt_pulse", int'(bus.wdt_err), WDT ? 1 : 0);
    @(negedge clk); chk("wdt_regrant", int'(bus.gnt), 1); chk("wdt_clear", int'(bus.wdt_err), 0);

    // asynchronous reset in the middle of the lock
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    chk("arst_gnt",   int'(bus.gnt), 0);
    chk("arst_busy",  int'(bus.busy), 0);
    chk("arst_owner", int'(bus.owner), 0);
    chk("arst_wdt",   int'(bus.wdt_err), 0);
    @(negedge clk); bus.req = 2'b10; bus.lock = 2'b00;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); chk("post_rst_gnt", int'(bus.gnt), 2); chk("post_rst_owner", int'(bus.owner), 1);

    // random traffic, lock biased high to exercise long holds
    bus.req = 2'b00;
    @(negedge clk);
    rnd_on = 1'b1;
    repeat (10000) begin
      @(negedge clk);
      bus.req  = 2'($urandom_range(0, 3));
      bus.lock = {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)};
    end
    @(negedge clk);
    rnd_on   = 1'b0;
    bus.req  = 2'b00;
    bus.lock = 2'b00;
    repeat (2) @(negedge clk);
    chk("final_idle", int'(bus.busy), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/exu_gpr_arb.md
# exu_gpr_arb

Round-robin arbiter that shares the single GPR read/write port between `CHN_NUM` execution-unit requesters. It sits in front of `exu_gpr_rw_mux`: its one-hot `gnt` vector drives the mux's `chn_sels` directly, so exactly one channel (or none) owns `gpr_dst_mst` in any cycle. Requesters may lock the port across consecutive cycles for multi-beat sequences such as read-modify-write or a dual writeback. An optional watchdog bounds how long a lock can be held.

## Interface
- `CHN_NUM`, default 2: number of requesters; legal range 2..8.
- `MAX_HOLD`, default 16: maximum consecutive locked grant cycles before forced release; legal range 2..255. Used only with the watchdog.
- `clk` input 1: clock; all state updates on the rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `req[CHN_NUM]` input 1 each: channel i requests the GPR port; held high until granted.
- `lock[CHN_NUM]` input 1 each: channel i wants to keep the port after the current granted cycle; sampled only while `gnt[i]` is high.
- `gnt[CHN_NUM]` output 1 each: registered one-hot-or-zero grant; connects to `exu_gpr_rw_mux.chn_sels`.
- `busy` output 1: registered; equals the OR of `gnt`.
- `owner` output `$clog2(CHN_NUM)`: registered index of the granted channel; 0 when `busy` is low.
- `wdt_err` output 1: registered one-cycle pulse on a forced release.

## Operation
- States:
  - IDLE: `gnt` is all zero.
  - GRANT: exactly one `gnt` bit is high, selecting `owner`.
- A cycle with `gnt[i]` high is an access cycle for channel i. The GPR read data it sees and the write it drives apply in that cycle; the write commits at the closing edge.
- IDLE transitions:
  - any `req` high: go to GRANT with the round-robin winner.
  - no `req` high: stay in IDLE.
- GRANT, hold: stay on the same owner if `req[owner]` & `lock[owner]` are both high and no watchdog expiry occurs.
- GRANT, release: any other case.
  - Re-arbitrate among all `req` bits with no idle bubble.
  - If no `req` is high, go to IDLE.
- Round-robin rule:
  - Search starts at `last+1` mod `CHN_NUM` and wraps.
  - `last` is the most recent owner; it resets to `CHN_NUM-1`, so channel 0 wins first after reset.
  - The previous owner is eligible again only after every other channel has been checked.
- Unlocked requester: receives exactly one grant cycle per arbitration. A channel that keeps `req` high with `lock` low is re-granted only when it is next in round-robin order.
- `req` dropping while granted (lock ignored): release takes effect at the next edge.
- Simultaneous events: the owner releasing in the same cycle as other channels requesting hands off directly to the next channel in round-robin order.
- `lock` without `req`: has no effect.
- Reset, asserted at any time including mid-lock:
  - `gnt` = 0, `busy` = 0, `owner` = 0, `wdt_err` = 0, `last` = `CHN_NUM-1`, watchdog counter = 0.
  - After reset deasserts, the first arbitration happens at the first rising edge.

## Timing
- Grant latency from IDLE: `req` is sampled high at edge N, and `gnt` is high in the cycle following edge N. Minimum latency is 1 cycle.
- Handoff: the owner's last access cycle is immediately followed by the next owner's first access cycle. There is zero dead cycles.
- All outputs are flops. There is no combinational path from `req`/`lock` to `gnt`.

## Configuration
- Macro: `EXU_GPR_ARB_WDT_EN`.
- Defined:
  - An 8-bit hold counter clears on every new grant and increments each held cycle.
  - When the counter reaches `MAX_HOLD-1` while a hold is requested, the arbiter forces a release and `wdt_err` pulses for 1 cycle.
  - That owner is excluded from the immediately following arbitration, even if it is the only requester; in that case the arbiter goes to IDLE for 1 cycle.
- Undefined: no counter is built, `wdt_err` is tied to 0, and a lock may be held indefinitely.

## Test plan
- Reset release with `req`={1,1}: `gnt` is {1,0} in cycle 1 and {0,1} in cycle 2, alternating while both are held; `lock`=0.
- Single requester ch1, `req` held 3 cycles, `lock`=0: `gnt[1]` is high in cycles 1..3 (re-granted each time as the only requester); `owner`=1; IDLE after `req` drops.
- Ch0 holds `lock`=1 for 4 granted cycles while ch1 requests: `gnt[0]` stays high for 4 cycles, then `gnt[1]` rises at the very next cycle with no idle gap.
- `EXU_GPR_ARB_WDT_EN` with `MAX_HOLD`=4, ch0 locked forever: `gnt[0]` stays high for exactly 4 cycles, `wdt_err` pulses once, then 1 IDLE cycle, then `gnt[0]` is high again.
- `rst_n` asserted mid-lock: `gnt`, `busy`, `owner` and `wdt_err` clear immediately (asynchronously); after release with `req`={0,1}, ch1 is granted in 1 cycle.
- Random `req`/`lock` over 10k cycles: `gnt` is always one-hot-or-zero, `busy` == |`gnt`, and no requester waits more than (`CHN_NUM`-1)*`MAX_HOLD` cycles (checked with the watchdog enabled).
